// File: rtl/cpu_seq32.sv
// cpu_seq32: multi-cycle control sequencer for the 32-bit ARM-subset CPU.
// Walks each instruction through FETCH/DECODE/EXEC/MEM/WB, owns the PC and
// raises every memory request and register/CPSR write strobe.
module cpu_seq32 #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [3:0]  cpsr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic [31:0] ir,
  output logic [31:0] pc,
  output logic [31:0] link_addr,
  output logic [1:0]  wb_sel,
  output logic        reg_we,
  output logic        cpsr_we,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_t;

  state_t cur, nxt;

  // Condition-code check; flags are {N,Z,C,V}.
  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      4'h0: cond_pass = z;
      4'h1: cond_pass = !z;
      4'h2: cond_pass = cf;
      4'h3: cond_pass = !cf;
      4'h4: cond_pass = n;
      4'h5: cond_pass = !n;
      4'h6: cond_pass = v;
      4'h7: cond_pass = !v;
      4'h8: cond_pass = cf & !z;
      4'h9: cond_pass = !cf | z;
      4'hA: cond_pass = (n == v);
      4'hB: cond_pass = (n != v);
      4'hC: cond_pass = !z & (n == v);
      4'hD: cond_pass = z | (n != v);
      4'hE: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

  logic [2:0]  opc;
  logic        is_dp, is_ls, is_br, cond_ok;
  logic [31:0] pc_plus4, br_target;
  state_t      bnd;

  assign opc       = ir[27:25];
  assign is_dp     = (opc[2:1] == 2'b00);
  assign is_ls     = (opc[2:1] == 2'b01);
  assign is_br     = (opc == 3'b101);
  assign cond_ok   = cond_pass(ir[31:28], cpsr);
  assign pc_plus4  = pc + 32'd4;
  assign br_target = pc + 32'd8 + {{6{ir[23]}}, ir[23:0], 2'b00};
  // Instruction boundary: run is only honoured here.
  assign bnd       = run ? S_FETCH : S_IDLE;

  // Moore outputs decoded from state and the latched instruction.
  assign state     = cur;
  assign imem_req  = (cur == S_FETCH);
  assign imem_addr = pc;
  assign dmem_req  = (cur == S_MEM);
  assign dmem_we   = (cur == S_MEM) & ~ir[20];
  assign reg_we    = (cur == S_WB);
  assign cpsr_we   = (cur == S_WB) & is_dp & ir[20];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) cur <= S_IDLE;
    else     cur <= nxt;
  end

  // Next-state decode.
  always_comb begin
    nxt = cur;
    case (cur)
      S_IDLE:   if (run) nxt = S_FETCH;
      S_FETCH:  if (imem_ack) nxt = S_DECODE;
      S_DECODE: nxt = cond_ok ? S_EXEC : bnd;
      S_EXEC: begin
        if (is_dp)      nxt = S_WB;
        else if (is_ls) nxt = S_MEM;
        else if (is_br) nxt = ir[24] ? S_WB : bnd;
        else            nxt = bnd;
      end
      S_MEM:    if (dmem_ack) nxt = ir[20] ? S_WB : bnd;
      S_WB:     nxt = bnd;
      default:  nxt = S_IDLE;
    endcase
  end

  // PC, IR, link address and writeback-source registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_PC;
      ir        <= '0;
      link_addr <= '0;
      wb_sel    <= '0;
    end else begin
      case (cur)
        S_FETCH:  if (imem_ack) ir <= imem_rdata;
        S_DECODE: if (!cond_ok) pc <= pc_plus4;
        S_EXEC: begin
          if (is_dp) begin
            wb_sel <= 2'd0;
          end else if (is_br) begin
            pc <= br_target;
            if (ir[24]) begin
              link_addr <= pc_plus4;
              wb_sel    <= 2'd2;
            end
          end else if (!is_ls) begin
            pc <= pc_plus4;            // undefined opcode runs as a NOP
          end
        end
        S_MEM: begin
          if (dmem_ack) begin
            if (ir[20]) wb_sel <= 2'd1;
            else        pc     <= pc_plus4;
          end
        end
        S_WB:     if (!is_br) pc <= pc_plus4;  // BL already retargeted pc
        default: ;
      endcase
    end
  end

endmodule
